dmshr_mem_arb: RTL and testbench
================================

# dmshr_mem_arb

Memory-request arbiter directly downstream of the dcache MSHR entry array. Collects per-entry line-fill requests, picks one per cycle round-robin, and presents it on a registered valid/ready request channel toward the CHI/bus side. Tracks which MSHR IDs have a fill in flight, and routes returning line data back to the owning entry as a one-hot refill strobe.

## Interface
Parameters:
- MSHR_NUM, 4: number of MSHR entries; also the number of IDs.
- PADDR_WIDTH, 64: physical address width, equal to the `PADDR_RANGE` width.
- LINE_WIDTH, 512: cache-line data width (64-byte line).
- MAX_OUTSTANDING, 4: maximum concurrent fills; legal range 1..MSHR_NUM.
- ID_WIDTH, $clog2(MSHR_NUM): request/response ID width; minimum 1.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  MSHR_NUM  per-entry fill request.
- req_paddr  in  MSHR_NUM*PADDR_WIDTH  per-entry address; entry i occupies bits [i*PADDR_WIDTH +: PADDR_WIDTH].
- req_grant  out  MSHR_NUM  one-hot, one-cycle pulse: entry won arbitration (win_chi_arb).
- mem_req_valid  out  1  request to the bus side.
- mem_req_ready  in  1  bus side accepts the request.
- mem_req_paddr  out  PADDR_WIDTH  line-aligned address.
- mem_req_id  out  ID_WIDTH  index of the issuing MSHR entry.
- mem_resp_valid  in  1  fill data return; single beat, no backpressure.
- mem_resp_id  in  ID_WIDTH  ID of the returning fill.
- mem_resp_data  in  LINE_WIDTH  full line.
- resp_valid  out  MSHR_NUM  one-hot refill strobe to the owning entry (chi_arb_resp_valid).
- resp_data  out  LINE_WIDTH  registered line data.
- resp_err  out  1  sticky error flag: response received with an ID that is not in flight.

## Operation
- State per ID: busy[i]. Global state: out_cnt (popcount of busy, width $clog2(MAX_OUTSTANDING+1)), rr_ptr (ID_WIDTH), plus the output slot (mem_req_valid/paddr/id).
- Eligible(i) = req_valid[i] & ~busy[i].
- Slot free = ~mem_req_valid | mem_req_ready.
- Arbitration runs when the slot is free and out_cnt < MAX_OUTSTANDING.
  - Winner: the first eligible i searching from rr_ptr upward, wrapping at MSHR_NUM-1 to 0.
- On a win:
  - Load the slot: mem_req_paddr = req_paddr[winner] with bits [5:0] forced to 0; mem_req_id = winner; mem_req_valid = 1.
  - Pulse req_grant[winner] for 1 cycle.
  - Set busy[winner]; increment out_cnt.
  - rr_ptr = winner+1, wrapping to 0 after MSHR_NUM-1.
- Slot FSM:
  - EMPTY -> FULL on a win.
  - FULL -> EMPTY on ready with no new win.
  - FULL -> FULL on ready with a new win (back-to-back).
  - FULL holds, with contents stable, while ready=0.
- Entries drop req_valid the cycle after the grant. Because busy is already set, a late req_valid cannot be granted twice.
- Response, with `DMSHR_RESP_CHECK_EN` (see Configuration) defined:
  - If busy[mem_resp_id]: resp_valid[mem_resp_id]=1 and resp_data=mem_resp_data on the next cycle; clear busy; decrement out_cnt.
  - Otherwise: drop the response and set resp_err.
- Simultaneous win and response in one cycle: out_cnt unchanged.
  - A response may free an ID that wins in the same cycle only from the next cycle, because eligibility uses the pre-update busy.
- Reset values:
  - All zero: mem_req_valid, mem_req_paddr, mem_req_id, req_grant, resp_valid, resp_data, resp_err, busy, out_cnt, rr_ptr.
  - Reset mid-operation discards the in-flight slot and all busy state. The bus side is reset in the same cycle.

## Timing
- Request to bus, best case: req_valid at cycle N, then req_grant and mem_req_valid at N+1.
- Throughput: one grant per cycle while ready=1 and capacity remains.
- Response: mem_resp_valid at cycle N gives resp_valid at N+1. Strobe lasts exactly 1 cycle; resp_data holds its value until the next response.
- Handshake rule: mem_req_paddr and mem_req_id are stable while mem_req_valid=1 and mem_req_ready=0. mem_req_valid never drops without ready.
- No combinational path from any input to any output.

## Configuration
- `DMSHR_RESP_CHECK_EN` defined:
  - ID check active as described in Operation.
  - resp_err is functional and sticky until reset.
- Undefined:
  - resp_err is tied to 0.
  - Every mem_resp_valid is routed to resp_valid[mem_resp_id] and clears that busy bit unconditionally.
  - out_cnt saturates at 0; it never underflows.

## Test plan
- Reset, then req_valid=4'b0001, paddr0=0x8000_1234, ready=1 -> cycle+1: grant=0001, mem_req_paddr=0x8000_1200, id=0; a resp with id=0 returns resp_valid=0001 one cycle later.
- req_valid=4'b1111 held, ready=1 -> grants 0001, 0010, 0100, 1000 on consecutive cycles; then no grant, because out_cnt=4=MAX_OUTSTANDING.
- ready=0 for 5 cycles with a request in the slot -> paddr/id unchanged, valid stays 1, no further grants; ready=1 -> next grant in the same cycle.
- All 4 busy; resp id=2 arrives while req_valid[2]=1 -> resp_valid=0100 at +1; grant to entry 2 at +1 at the earliest, not earlier.
- With `DMSHR_RESP_CHECK_EN`: mem_resp_valid with id=3 while busy=0 -> resp_valid stays 0, resp_err=1 and stays 1 until reset.
- Reset asserted while the slot is FULL and ready=0 -> next cycle mem_req_valid=0, busy=0, rr_ptr=0.

Source files
------------

// File: rtl/dmshr_mem_arb_if.sv
// Bus-side channel of the dcache MSHR fill arbiter: registered request out, single-beat line fill back.
interface dmshr_mem_arb_if #(
  parameter int PADDR_WIDTH = 64,
  parameter int LINE_WIDTH  = 512,
  parameter int ID_WIDTH    = 2
);
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [PADDR_WIDTH-1:0] mem_req_paddr;
  logic [ID_WIDTH-1:0]    mem_req_id;
  logic                   mem_resp_valid;
  logic [ID_WIDTH-1:0]    mem_resp_id;
  logic [LINE_WIDTH-1:0]  mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_paddr, mem_req_id,
    input  mem_req_ready, mem_resp_valid, mem_resp_id, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_paddr, mem_req_id,
    output mem_req_ready, mem_resp_valid, mem_resp_id, mem_resp_data
  );
endinterface

// File: rtl/dmshr_mem_arb.sv
// Round-robin fill-request arbiter between the MSHR entries and the bus, with in-flight ID tracking.
// Optional response ID checking and sticky resp_err under `DMSHR_RESP_CHECK_EN.
module dmshr_mem_arb #(
  parameter int MSHR_NUM        = 4,
  parameter int PADDR_WIDTH     = 64,
  parameter int LINE_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_WIDTH        = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [MSHR_NUM-1:0]             req_valid,
  input  logic [MSHR_NUM*PADDR_WIDTH-1:0] req_paddr,
  output logic [MSHR_NUM-1:0]             req_grant,
  dmshr_mem_arb_if.master                 mem,
  output logic [MSHR_NUM-1:0]             resp_valid,
  output logic [LINE_WIDTH-1:0]           resp_data,
  output logic                            resp_err
);

  localparam int CNT_W = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1;
  localparam logic [PADDR_WIDTH-1:0] LINE_MASK = ~PADDR_WIDTH'(63);

  // Slot states: EMPTY = nothing offered to the bus, FULL = request held until mem_req_ready.
  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  logic [0:0]             slot_state;
  logic [PADDR_WIDTH-1:0] slot_paddr;
  logic [ID_WIDTH-1:0]    slot_id;
  logic [MSHR_NUM-1:0]    busy;
  logic [CNT_W-1:0]       out_cnt;
  logic [ID_WIDTH-1:0]    rr_ptr;

  logic [MSHR_NUM-1:0]    eligible;
  logic                   slot_free;
  logic                   arb_en;
  logic                   win;
  int                     idx;
  logic [ID_WIDTH-1:0]    win_id;
  logic [PADDR_WIDTH-1:0] win_paddr;
  logic [MSHR_NUM-1:0]    win_oh;
  logic [ID_WIDTH-1:0]    rr_next;
  logic [MSHR_NUM-1:0]    resp_oh;
  logic [MSHR_NUM-1:0]    resp_hit;
  logic [MSHR_NUM-1:0]    resp_clr;

  assign eligible  = req_valid & ~busy;
  assign slot_free = (slot_state == SLOT_EMPTY) | mem.mem_req_ready;
  assign arb_en    = slot_free & (out_cnt < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    win       = 1'b0;
    win_id    = '0;
    win_paddr = '0;
    idx       = 0;
    for (int k = 0; k < MSHR_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= MSHR_NUM) idx = idx - MSHR_NUM;
      if (arb_en && !win && eligible[idx]) begin
        win       = 1'b1;
        win_id    = ID_WIDTH'(idx);
        win_paddr = req_paddr[idx*PADDR_WIDTH +: PADDR_WIDTH];
      end
    end
  end

  assign win_oh  = win ? (MSHR_NUM'(1) << win_id) : '0;
  assign rr_next = (win_id == ID_WIDTH'(MSHR_NUM - 1)) ? '0 : win_id + 1'b1;

  // IDs beyond MSHR_NUM-1 shift out to an all-zero strobe and are dropped.
  assign resp_oh  = mem.mem_resp_valid ? (MSHR_NUM'(1) << mem.mem_resp_id) : '0;
  assign resp_hit = resp_oh & busy;
`ifdef DMSHR_RESP_CHECK_EN
  assign resp_clr = resp_hit;
`else
  assign resp_clr = resp_oh;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_state <= SLOT_EMPTY;
      slot_paddr <= '0;
      slot_id    <= '0;
      busy       <= '0;
      out_cnt    <= '0;
      rr_ptr     <= '0;
      req_grant  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      case (slot_state)
        SLOT_EMPTY: if (win) slot_state <= SLOT_FULL;
        SLOT_FULL:  if (mem.mem_req_ready && !win) slot_state <= SLOT_EMPTY;
        default:    slot_state <= SLOT_EMPTY;
      endcase

      if (win) begin
        slot_paddr <= win_paddr & LINE_MASK;
        slot_id    <= win_id;
        rr_ptr     <= rr_next;
      end

      // Win sets busy after the clear so a same-cycle response never masks a new grant.
      busy      <= (busy & ~resp_clr) | win_oh;
      req_grant <= win_oh;

      // Only responses that actually free a busy ID count down, so out_cnt stays the popcount.
      if (win && !(|resp_hit)) begin
        out_cnt <= out_cnt + 1'b1;
      end else if (!win && (|resp_hit) && (out_cnt != '0)) begin
        out_cnt <= out_cnt - 1'b1;
      end

      resp_valid <= resp_clr;
      if (|resp_clr) resp_data <= mem.mem_resp_data;
    end
  end

`ifdef DMSHR_RESP_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else if (mem.mem_resp_valid && !(|resp_hit)) begin
      resp_err <= 1'b1;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  assign mem.mem_req_valid = (slot_state == SLOT_FULL);
  assign mem.mem_req_paddr = slot_paddr;
  assign mem.mem_req_id    = slot_id;

endmodule

// File: tb/tb_dmshr_mem_arb.sv
// Directed, table-driven bench for dmshr_mem_arb; one table row = one clock cycle of stimulus and expectations.
module tb_dmshr_mem_arb;

  localparam int N  = 4;
  localparam int PW = 64;
  localparam int LW = 512;
  localparam int IW = 2;
`ifdef DMSHR_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_paddr;
  logic [N-1:0]    req_grant;
  logic [N-1:0]    resp_valid;
  logic [LW-1:0]   resp_data;
  logic            resp_err;

  dmshr_mem_arb_if #(.PADDR_WIDTH(PW), .LINE_WIDTH(LW), .ID_WIDTH(IW)) mem ();

  dmshr_mem_arb #(
    .MSHR_NUM(N), .PADDR_WIDTH(PW), .LINE_WIDTH(LW), .MAX_OUTSTANDING(4), .ID_WIDTH(IW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_paddr(req_paddr), .req_grant(req_grant),
    .mem(mem),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    logic [3:0] rv;
    bit         rdy;
    bit         rspv;
    logic [1:0] rid;
    logic [3:0] e_g;
    bit         e_mv;
    logic [1:0] e_id;
    logic [3:0] e_rv;
    bit         e_err;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] raw_pa [N];
  logic [PW-1:0] exp_pa [N];

  function automatic vec_t mk(bit rst, logic [3:0] rv, bit rdy, bit rspv, logic [1:0] rid,
                              logic [3:0] e_g, bit e_mv, logic [1:0] e_id, logic [3:0] e_rv, bit e_err);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rdy = rdy; v.rspv = rspv; v.rid = rid;
    v.e_g = e_g; v.e_mv = e_mv; v.e_id = e_id; v.e_rv = e_rv; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [LW-1:0] pat(int tag);
    return {16{32'hC0DE_0000 + 32'(tag)}};
  endfunction

  task automatic chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset              = 1'b0;
    req_valid          = '0;
    mem.mem_req_ready  = 1'b0;
    mem.mem_resp_valid = 1'b0;
    mem.mem_resp_id    = '0;
    mem.mem_resp_data  = '0;
  endtask

  vec_t vt [$];

  initial begin
    raw_pa[0] = 64'h0000_0000_8000_1234;  exp_pa[0] = 64'h0000_0000_8000_1200;
    raw_pa[1] = 64'h0000_0000_8000_2275;  exp_pa[1] = 64'h0000_0000_8000_2240;
    raw_pa[2] = 64'h0000_00FF_FFFF_FFC1;  exp_pa[2] = 64'h0000_00FF_FFFF_FFC0;
    raw_pa[3] = 64'hFFFF_FFFF_FFFF_FFFF;  exp_pa[3] = 64'hFFFF_FFFF_FFFF_FFC0;
    req_paddr = {raw_pa[3], raw_pa[2], raw_pa[1], raw_pa[0]};

    //            rst rv      rdy rspv rid  e_g     mv e_id e_rv    e_err
    vt.push_back(mk(0, 4'b0001, 1, 0, 2'd0, 4'b0001, 1, 2'd0, 4'b0000, 0)); // 0 single request
    vt.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 0));
    vt.push_back(mk(0, 4'b0000, 1, 1, 2'd0, 4'b0000, 0, 2'd0, 4'b0001, 0)); // 2 fill id0
    vt.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 0)); // 3 reset rr_ptr
    vt.push_back(mk(0, 4'b1111, 1, 0, 2'd0, 4'b0001, 1, 2'd0, 4'b0000, 0)); // 4 burst of four
    vt.push_back(mk(0, 4'b1110, 1, 0, 2'd0, 4'b0010, 1, 2'd1, 4'b0000, 0));
    vt.push_back(mk(0, 4'b1100, 1, 0, 2'd0, 4'b0100, 1, 2'd2, 4'b0000, 0));
    vt.push_back(mk(0, 4'b1000, 1, 0, 2'd0, 4'b1000, 1, 2'd3, 4'b0000, 0));
    vt.push_back(mk(0, 4'b1111, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 0)); // 8 capacity full
    vt.push_back(mk(0, 4'b0100, 1, 1, 2'd2, 4'b0000, 0, 2'd0, 4'b0100, 0)); // 9 resp id2, no same-cycle grant
    vt.push_back(mk(0, 4'b0100, 0, 0, 2'd0, 4'b0100, 1, 2'd2, 4'b0000, 0)); // 10 regrant id2
    vt.push_back(mk(0, 4'b0000, 0, 1, 2'd0, 4'b0000, 1, 2'd2, 4'b0001, 0)); // 11 stall begins
    vt.push_back(mk(0, 4'b0001, 0, 0, 2'd0, 4'b0000, 1, 2'd2, 4'b0000, 0));
    vt.push_back(mk(0, 4'b0001, 0, 0, 2'd0, 4'b0000, 1, 2'd2, 4'b0000, 0));
    vt.push_back(mk(0, 4'b0001, 0, 0, 2'd0, 4'b0000, 1, 2'd2, 4'b0000, 0));
    vt.push_back(mk(0, 4'b0001, 0, 0, 2'd0, 4'b0000, 1, 2'd2, 4'b0000, 0));
    vt.push_back(mk(0, 4'b0001, 1, 0, 2'd0, 4'b0001, 1, 2'd0, 4'b0000, 0)); // 16 back-to-back on ready
    vt.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 0));
    vt.push_back(mk(0, 4'b0000, 1, 1, 2'd1, 4'b0000, 0, 2'd0, 4'b0010, 0));
    vt.push_back(mk(0, 4'b0010, 1, 1, 2'd3, 4'b0010, 1, 2'd1, 4'b1000, 0)); // 19 win + resp together
    vt.push_back(mk(0, 4'b1000, 1, 0, 2'd0, 4'b1000, 1, 2'd3, 4'b0000, 0)); // 20 count must be 3 here
    vt.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 0));
    vt.push_back(mk(0, 4'b0000, 1, 1, 2'd0, 4'b0000, 0, 2'd0, 4'b0001, 0));
    vt.push_back(mk(0, 4'b0000, 1, 1, 2'd1, 4'b0000, 0, 2'd0, 4'b0010, 0));
    vt.push_back(mk(0, 4'b0000, 1, 1, 2'd2, 4'b0000, 0, 2'd0, 4'b0100, 0));
    vt.push_back(mk(0, 4'b0000, 1, 1, 2'd3, 4'b0000, 0, 2'd0, 4'b1000, 0));
    vt.push_back(mk(0, 4'b0000, 1, 1, 2'd3, 4'b0000, 0, 2'd0, CHK ? 4'b0000 : 4'b1000, CHK)); // 26 stray id3
    vt.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, CHK));
    vt.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 0));
    vt.push_back(mk(0, 4'b0001, 0, 0, 2'd0, 4'b0001, 1, 2'd0, 4'b0000, 0)); // 29 fill slot, ready low
    vt.push_back(mk(0, 4'b0001, 0, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0001, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 0)); // 31 reset while FULL
    vt.push_back(mk(0, 4'b0011, 1, 0, 2'd0, 4'b0001, 1, 2'd0, 4'b0000, 0)); // 32 busy and rr_ptr cleared

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst mem_req_valid", LW'(mem.mem_req_valid), '0);
    chk("rst mem_req_paddr", LW'(mem.mem_req_paddr), '0);
    chk("rst mem_req_id",    LW'(mem.mem_req_id), '0);
    chk("rst req_grant",     LW'(req_grant), '0);
    chk("rst resp_valid",    LW'(resp_valid), '0);
    chk("rst resp_data",     resp_data, '0);
    chk("rst resp_err",      LW'(resp_err), '0);

    foreach (vt[i]) begin
      @(negedge clock);
      reset              = vt[i].rst;
      req_valid          = vt[i].rv;
      mem.mem_req_ready  = vt[i].rdy;
      mem.mem_resp_valid = vt[i].rspv;
      mem.mem_resp_id    = vt[i].rid;
      mem.mem_resp_data  = pat(i);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d req_grant", i), LW'(req_grant), LW'(vt[i].e_g));
      chk($sformatf("v%0d mem_req_valid", i), LW'(mem.mem_req_valid), LW'(vt[i].e_mv));
      if (vt[i].e_mv) begin
        chk($sformatf("v%0d mem_req_id", i), LW'(mem.mem_req_id), LW'(vt[i].e_id));
        chk($sformatf("v%0d mem_req_paddr", i), LW'(mem.mem_req_paddr), LW'(exp_pa[vt[i].e_id]));
      end
      chk($sformatf("v%0d resp_valid", i), LW'(resp_valid), LW'(vt[i].e_rv));
      if (vt[i].e_rv != 4'b0000)
        chk($sformatf("v%0d resp_data", i), resp_data, pat(i));
      chk($sformatf("v%0d resp_err", i), LW'(resp_err), LW'(vt[i].e_err));
    end

    // Strobe and grant are single-cycle pulses; resp_data holds until the next fill.
    @(negedge clock);
    idle_inputs();
    mem.mem_req_ready  = 1'b1;
    mem.mem_resp_valid = 1'b1;
    mem.mem_resp_id    = 2'd0;
    mem.mem_resp_data  = pat(77);
    @(posedge clock);
    #1;
    chk("hold first resp_valid", LW'(resp_valid), LW'(4'b0001));
    chk("hold first resp_data", resp_data, pat(77));
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      mem.mem_resp_valid = 1'b0;
      mem.mem_resp_data  = pat(99);
      @(posedge clock);
      #1;
      chk($sformatf("hold c%0d resp_valid", c), LW'(resp_valid), '0);
      chk($sformatf("hold c%0d resp_data", c), resp_data, pat(77));
      chk($sformatf("hold c%0d req_grant", c), LW'(req_grant), '0);
      chk($sformatf("hold c%0d mem_req_valid", c), LW'(mem.mem_req_valid), '0);
    end

    // A freed ID is granted again; the new grant carries the re-aligned address.
    @(negedge clock);
    req_valid = 4'b0001;
    @(posedge clock);
    #1;
    chk("regrant req_grant", LW'(req_grant), LW'(4'b0001));
    chk("regrant mem_req_paddr", LW'(mem.mem_req_paddr), LW'(exp_pa[0]));
    @(negedge clock);
    req_valid = 4'b0001;
    @(posedge clock);
    #1;
    chk("late req_valid no regrant", LW'(req_grant), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
